id_ex_stage_buf: RTL and testbench

//  - Parametrised ID->EX pipeline stage with valid/ready flow control, flush and an optional skid entry.
//  - Replaces the fixed-field ID/EX latch; payload = {control bundle, PC, PC+4, rs1/rs2 data, imm, rd, funct3}, packed by the decode stage.
//  - Gives EX back-pressure (stall) and branch/jump squash (flush); bubbles are forced to NOP control.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/pipe_entry_reg.sv | 35 +++
 rtl/id_ex_stage_buf.sv | 176 +++++++++++++++++
 tb/tb_id_ex_stage_buf.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared ID/EX pipeline types, widths, NOP control value and
// the buffer state encoding used by id_ex_stage_buf.
package pipe_pkg;

   typedef struct packed {
      logic       reg_wr;
      logic       mem_rd;
      logic       mem_wr;
      logic       branch;
      logic       jump;
      logic       alu_src;
      logic [1:0] wb_sel;
      logic [4:0] alu_op;
      logic [2:0] rsvd;
   } id_ex_ctrl_t;

   typedef struct packed {
      logic        pred_taken;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [2:0]  funct3;
   } id_ex_data_t;

   localparam int ID_EX_CTRL_W = $bits(id_ex_ctrl_t);
   localparam int ID_EX_DATA_W = $bits(id_ex_data_t);

   localparam id_ex_ctrl_t ID_EX_CTRL_NOP = '0;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } buf_state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one pipeline entry (valid + ctrl + data).
// Ports: CLK, Reset (sync, active-high), load, clear, ctrl_d, data_d,
// valid, ctrl, data. Clear forces ctrl to CTRL_NOP and keeps data.
module pipe_entry_reg #(
   parameter int                CTRL_W   = 16,
   parameter int                DATA_W   = 169,
   parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] ctrl_d,
   input  logic [DATA_W-1:0] data_d,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge CLK) begin
      if (Reset) begin
         valid <= 1'b0;
         ctrl  <= CTRL_NOP;
         data  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= CTRL_NOP;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= ctrl_d;
         data  <= data_d;
      end
   end

endmodule

// File: rtl/id_ex_stage_buf.sv
// id_ex_stage_buf: ID->EX stage buffer with valid/ready, flush, bubble NOP.
// Ports: CLK, Reset, flush, in_valid/in_ready/in_ctrl/in_data,
// out_valid/out_ready/out_ctrl/out_data. Macro ID_EX_SKID_EN adds a skid
// entry so in_ready comes from registered state only.
module id_ex_stage_buf
   import pipe_pkg::*;
#(
   parameter int                CTRL_W   = ID_EX_CTRL_W,
   parameter int                DATA_W   = ID_EX_DATA_W,
   parameter logic [CTRL_W-1:0] CTRL_NOP = ID_EX_CTRL_NOP
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
);

   buf_state_t        st;
   buf_state_t        st_nxt;
   logic              in_xfer;
   logic              out_xfer;
   logic              m_load;
   logic              m_clr;
   logic              m_valid;
   logic [CTRL_W-1:0] m_ctrl;
   logic [DATA_W-1:0] m_data;
   logic [CTRL_W-1:0] m_ctrl_d;
   logic [DATA_W-1:0] m_data_d;

   always_ff @(posedge CLK) begin
      if (Reset) st <= ST_EMPTY;
      else       st <= st_nxt;
   end

   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = m_valid & out_ready;
   assign out_valid = m_valid;
   assign out_ctrl  = m_ctrl;
   assign out_data  = m_data;

   pipe_entry_reg #(
      .CTRL_W  (CTRL_W),
      .DATA_W  (DATA_W),
      .CTRL_NOP(CTRL_NOP)
   ) u_main (
      .CLK   (CLK),
      .Reset (Reset),
      .load  (m_load),
      .clear (m_clr),
      .ctrl_d(m_ctrl_d),
      .data_d(m_data_d),
      .valid (m_valid),
      .ctrl  (m_ctrl),
      .data  (m_data)
   );

`ifdef ID_EX_SKID_EN

   logic              s_load;
   logic              s_clr;
   logic              m_from_skid;
   logic              s_valid;
   logic [CTRL_W-1:0] s_ctrl;
   logic [DATA_W-1:0] s_data;

   // Registered ready: the skid absorbs the one entry that may arrive
   // in the cycle EX stalls.
   assign in_ready = (st != ST_FULL);
   assign m_ctrl_d = m_from_skid ? s_ctrl : in_ctrl;
   assign m_data_d = m_from_skid ? s_data : in_data;

   pipe_entry_reg #(
      .CTRL_W  (CTRL_W),
      .DATA_W  (DATA_W),
      .CTRL_NOP(CTRL_NOP)
   ) u_skid (
      .CLK   (CLK),
      .Reset (Reset),
      .load  (s_load),
      .clear (s_clr),
      .ctrl_d(in_ctrl),
      .data_d(in_data),
      .valid (s_valid),
      .ctrl  (s_ctrl),
      .data  (s_data)
   );

   always_comb begin
      st_nxt      = st;
      m_load      = 1'b0;
      m_clr       = 1'b0;
      m_from_skid = 1'b0;
      s_load      = 1'b0;
      s_clr       = 1'b0;
      if (flush) begin
         st_nxt = ST_EMPTY;
         m_clr  = 1'b1;
         s_clr  = 1'b1;
      end else begin
         unique case (st)
            ST_EMPTY: begin
               if (in_xfer) begin
                  m_load = 1'b1;
                  st_nxt = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  m_load = 1'b1;
               end else if (in_xfer) begin
                  s_load = 1'b1;
                  st_nxt = ST_FULL;
               end else if (out_xfer) begin
                  m_clr  = 1'b1;
                  st_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // Older entry leaves first; skid refills main.
               if (out_xfer && s_valid) begin
                  m_load      = 1'b1;
                  m_from_skid = 1'b1;
                  s_clr       = 1'b1;
                  st_nxt      = ST_ONE;
               end
            end
            default: st_nxt = ST_EMPTY;
         endcase
      end
   end

`else

   assign in_ready = ~m_valid | out_ready;
   assign m_ctrl_d = in_ctrl;
   assign m_data_d = in_data;

   always_comb begin
      st_nxt = st;
      m_load = 1'b0;
      m_clr  = 1'b0;
      if (flush) begin
         st_nxt = ST_EMPTY;
         m_clr  = 1'b1;
      end else begin
         unique case (st)
            ST_EMPTY: begin
               if (in_xfer) begin
                  m_load = 1'b1;
                  st_nxt = ST_ONE;
               end
            end
            ST_ONE: begin
               // in_xfer here implies out_xfer: ready needs the slot freed.
               if (in_xfer) begin
                  m_load = 1'b1;
               end else if (out_xfer) begin
                  m_clr  = 1'b1;
                  st_nxt = ST_EMPTY;
               end
            end
            default: st_nxt = ST_EMPTY;
         endcase
      end
   end

`endif

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// tb_id_ex_stage_buf: directed self-checking bench for id_ex_stage_buf.
// Covers both builds; ID_EX_SKID_EN selects the skid expectations.
module tb_id_ex_stage_buf;

   localparam int CW = 16;
   localparam int DW = 169;

   logic          CLK;
   logic          Reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;

   int checks = 0;
   int errors = 0;

   id_ex_stage_buf dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_ctrl  (in_ctrl),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_ctrl (out_ctrl),
      .out_data (out_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag,
                      input logic [255:0] got,
                      input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [DW-1:0] dv(input logic [31:0] k);
      dv = {k[0], 72'd0, k, ~k, k ^ 32'hA5A5_A5A5};
   endfunction

   function automatic logic [CW-1:0] cv(input logic [31:0] k);
      cv = 16'h0100 + k[15:0] + 16'd1;
   endfunction

   task automatic push(input int k);
      in_valid = 1'b1;
      in_ctrl  = cv(k);
      in_data  = dv(k);
      tick;
   endtask

   initial begin
      Reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 16'hBEEF;
      in_data   = dv(99);
      out_ready = 1'b1;

      // reset held two cycles with in_valid high
      tick;
      tick;
      chk("rst_v", out_valid, 1'b0);
      chk("rst_c", out_ctrl, 16'h0);
      chk("rst_d", out_data, '0);
      Reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_rdy", in_ready, 1'b1);
      tick;
      chk("rst_v2", out_valid, 1'b0);

      // streaming, one-cycle latency
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_ctrl  = cv(i);
         in_data  = dv(i);
         #1;
         chk("strm_rdy", in_ready, 1'b1);
         tick;
         chk("strm_v", out_valid, 1'b1);
         chk("strm_c", out_ctrl, cv(i));
         chk("strm_d", out_data, dv(i));
      end
      in_valid = 1'b0;
      tick;
      chk("strm_end_v", out_valid, 1'b0);
      chk("strm_end_c", out_ctrl, 16'h0);

      // back-pressure with A then B
      out_ready = 1'b0;
`ifdef ID_EX_SKID_EN
      push(10);
      chk("bp_a_v", out_valid, 1'b1);
      chk("bp_a_d", out_data, dv(10));
      chk("bp_a_rdy", in_ready, 1'b1);
      push(11);
      chk("bp_full_rdy", in_ready, 1'b0);
      chk("bp_full_d", out_data, dv(10));
      chk("bp_full_c", out_ctrl, cv(10));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick;
      chk("bp_b_v", out_valid, 1'b1);
      chk("bp_b_d", out_data, dv(11));
      chk("bp_b_c", out_ctrl, cv(11));
      chk("bp_b_rdy", in_ready, 1'b1);
      tick;
      chk("bp_done_v", out_valid, 1'b0);
`else
      push(10);
      chk("bp_a_d", out_data, dv(10));
      in_ctrl = cv(11);
      in_data = dv(11);
      #1;
      chk("bp_stall_rdy", in_ready, 1'b0);
      tick;
      chk("bp_hold_d", out_data, dv(10));
      chk("bp_hold_c", out_ctrl, cv(10));
      out_ready = 1'b1;
      #1;
      chk("bp_go_rdy", in_ready, 1'b1);
      tick;
      chk("bp_b_v", out_valid, 1'b1);
      chk("bp_b_d", out_data, dv(11));
      in_valid = 1'b0;
      tick;
      chk("bp_done_v", out_valid, 1'b0);
`endif

      // flush with a handshaking input C
      out_ready = 1'b0;
      push(20);
`ifdef ID_EX_SKID_EN
      push(21);
`endif
      in_valid  = 1'b1;
      in_ctrl   = cv(22);
      in_data   = dv(22);
      flush     = 1'b1;
      out_ready = 1'b1;
      tick;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_v", out_valid, 1'b0);
      chk("fl_c", out_ctrl, 16'h0);
      chk("fl_rdy", in_ready, 1'b1);
      tick;
      chk("fl_noc_v", out_valid, 1'b0);
      chk("fl_noc_c", out_ctrl, 16'h0);

      // flush from empty drops the accepted input
      in_valid = 1'b1;
      in_ctrl  = cv(23);
      in_data  = dv(23);
      flush    = 1'b1;
      tick;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_e_v", out_valid, 1'b0);
      tick;
      chk("fl_e_v2", out_valid, 1'b0);

      // stall-stable entry 0x1234
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 16'h1234;
      in_data   = 169'h1234;
      tick;
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("stl_v", out_valid, 1'b1);
         chk("stl_c", out_ctrl, 16'h1234);
         chk("stl_d", out_data, 169'h1234);
         tick;
      end
      out_ready = 1'b1;
      tick;
      chk("stl_out_v", out_valid, 1'b0);
      tick;
      chk("stl_out_v2", out_valid, 1'b0);

      // reset and flush together while holding entries
      out_ready = 1'b0;
      push(30);
`ifdef ID_EX_SKID_EN
      push(31);
      chk("rf_full_rdy", in_ready, 1'b0);
`endif
      in_valid = 1'b0;
      Reset    = 1'b1;
      flush    = 1'b1;
      tick;
      chk("rf_v", out_valid, 1'b0);
      chk("rf_c", out_ctrl, 16'h0);
      chk("rf_d", out_data, '0);
      Reset = 1'b0;
      flush = 1'b0;
      #1;
      chk("rf_rdy", in_ready, 1'b1);
      tick;
      chk("rf_v2", out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
